// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register, redirect/halt sequencing and IF/ID/EX flush control
module pc_sequencer #(
    parameter int PC_W         = 9,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic             PcSel,
    input  logic [31:0]      BrPC,
    input  logic             Halt,
    input  logic             Resume,
    output logic [PC_W-1:0]  Cur_PC,
    output logic             Flush_IfId,
    output logic             Flush_IdEx,
    output logic             Halted,
    output logic [PC_W-1:0]  Halt_PC,
    output logic             Align_Err,
    output logic [CNT_W-1:0] redirect_count
);
    typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

    state_t           state, state_n;
    logic [1:0]       cnt, cnt_n;
    logic [PC_W-1:0]  pc_n, hpc_n;
    logic [CNT_W-1:0] rc_n;
    logic             align_n, flush;

    assign Flush_IfId = flush;
    assign Flush_IdEx = flush;
    assign Halted     = (state == HALTED);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pc_n    = Cur_PC;
        hpc_n   = Halt_PC;
        rc_n    = redirect_count;
        align_n = Align_Err;
        flush   = 1'b0;
        case (state)
            RUN: begin
                if (PcSel) begin
                    flush   = 1'b1;
                    align_n = Align_Err | (|BrPC[1:0]) | (|BrPC[31:PC_W]);
                    if (Halt) begin
                        pc_n    = BrPC[PC_W-1:0];
                        hpc_n   = BrPC[PC_W-1:0];
                        state_n = HALTED;
                    end else begin
                        pc_n = {BrPC[PC_W-1:2], 2'b00};
                        rc_n = &redirect_count ? redirect_count : redirect_count + 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_n = FLUSH;
                            cnt_n   = 2'(FLUSH_CYCLES - 1);
                        end
                    end
                end else if (!Stall) begin
                    pc_n = Cur_PC + PC_W'(4);
                end
            end
            FLUSH: begin
                flush   = 1'b1;
                pc_n    = Cur_PC + PC_W'(4);
                cnt_n   = cnt - 2'd1;
                state_n = (cnt == 2'd1) ? RUN : FLUSH;
            end
            HALTED: begin
                flush = 1'b1;
                if (Resume) begin
                    pc_n    = Halt_PC + PC_W'(4);
                    state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            cnt            <= '0;
            Cur_PC         <= '0;
            Halt_PC        <= '0;
            Align_Err      <= 1'b0;
            redirect_count <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            Cur_PC         <= pc_n;
            Halt_PC        <= hpc_n;
            Align_Err      <= align_n;
            redirect_count <= rc_n;
        end
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the program counter register and sequences instruction fetch for the single-issue pipeline. Each cycle it picks the next PC from sequential PC+4, the EX-stage redirect (taken branch, jump, JALR, halt) produced by the branch-resolution logic, or hold (stall/halt). It generates the pipeline flush controls that accompany a redirect, runs a RUN/FLUSH/HALTED state machine, and keeps redirect statistics and an alignment-error flag.

Parameters:
PC_W, 9, width of the fetch PC; next-PC arithmetic wraps modulo 2^PC_W
FLUSH_CYCLES, 1, cycles of IF/ID flush per redirect, including the redirect cycle; legal range 1..3
CNT_W, 16, width of redirect_count

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
Stall  input  1  hazard unit requests PC hold (load-use)
PcSel  input  1  EX-stage redirect request from branch resolution
BrPC  input  32  redirect target; valid when PcSel=1
Halt  input  1  EX-stage instruction is a halt; qualifies PcSel
Resume  input  1  external restart pulse; only honoured in HALTED
Cur_PC  output  PC_W  current fetch PC, registered
Flush_IfId  output  1  squash the IF/ID register this cycle
Flush_IdEx  output  1  squash the ID/EX register this cycle
Halted  output  1  high while in HALTED, registered
Halt_PC  output  PC_W  PC of the halting instruction, registered
Align_Err  output  1  sticky; set when a redirect target is misaligned or out of range
redirect_count  output  CNT_W  count of taken non-halt redirects, saturating

Behaviour:
- Reset: Cur_PC=0, state=RUN, Halted=0, Halt_PC=0, Align_Err=0, redirect_count=0, flush counter=0.
- Reset takes priority over every other input in the same cycle. Reset during FLUSH or HALTED returns to RUN with PC=0.
- Flush_IfId and Flush_IdEx are combinational (Mealy) from state and inputs. Everything else is registered.
- RUN, priority order:
  - PcSel=1, Halt=1: Cur_PC<=BrPC[PC_W-1:0]; Halt_PC<=BrPC[PC_W-1:0]; go to HALTED. Flush_IfId=Flush_IdEx=1 this cycle. Counter not incremented.
  - PcSel=1, Halt=0: Cur_PC<=BrPC[PC_W-1:0] with bits [1:0] forced to 0. Flush_IfId=Flush_IdEx=1 this cycle. redirect_count += 1, holding at all-ones. If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1; otherwise stay in RUN.
  - PcSel=0, Stall=1: hold Cur_PC; no flush.
  - Otherwise: Cur_PC<=Cur_PC+4, wrapping modulo 2^PC_W.
- PcSel overrides Stall: an EX redirect always wins.
- Align_Err is set on any PcSel=1 cycle in RUN where BrPC[1:0]!=0 or BrPC[31:PC_W]!=0. It clears only on reset.
- FLUSH:
  - Flush_IfId=1 and Flush_IdEx=1 every cycle.
  - PC advances +4; Stall is ignored because the fetched slots are squashed anyway.
  - PcSel and Halt are ignored, since the EX slot holds a bubble.
  - Counter decrements; on reaching 0, return to RUN. Total flush length equals FLUSH_CYCLES exactly.
- HALTED:
  - Halted=1; Cur_PC held; Flush_IfId=1 and Flush_IdEx=1 continuously so nothing enters the pipe.
  - Stall and PcSel are ignored.
  - Resume=1: Cur_PC<=Halt_PC+4 (wrapping), go to RUN; Halted drops the next cycle. Flushes deassert in the cycle after Resume.
  - Resume outside HALTED has no effect.
- Next-PC adder is PC_W bits wide; the carry is discarded, e.g. 0x1FC+4 -> 0x000 at PC_W=9.
- Latency: a redirect presented in cycle N appears on Cur_PC in cycle N+1.

Test Plan:
- Reset then 4 free-running cycles, Stall=0, PcSel=0 -> Cur_PC = 0,4,8,12,16; no flush; redirect_count=0.
- At Cur_PC=0x010, Stall=1 for 2 cycles, then PcSel=1 with BrPC=0x40 while Stall=1 -> PC holds 0x010 for the 2 stalled cycles, next PC=0x040, both flushes high in the redirect cycle, redirect_count=1.
- FLUSH_CYCLES=3, PcSel=1, BrPC=0x80, then PcSel=1, BrPC=0x20 during the next 2 cycles -> PC=0x80,0x84,0x88, flushes high 3 consecutive cycles, second redirect ignored, redirect_count=1.
- PcSel=1, Halt=1, BrPC=0x24 -> Halted=1, Cur_PC=Halt_PC=0x24 held for 5 cycles with flushes high; Resume pulse -> Cur_PC=0x28, Halted=0.
- PcSel=1 with BrPC=0x00000206 at PC_W=9 -> Align_Err=1 and stays 1; Cur_PC=0x004; PC at 0x1FC free-running -> next 0x000.
- Reset asserted while HALTED and Resume=1 in the same cycle -> Cur_PC=0, state RUN, Halted=0, Align_Err=0, redirect_count=0.
